// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
//   arb_state_e : arbiter FSM states
//   F3_*        : load/store size codes carried on func3
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_D = 2'd1,
    SERVE_I = 2'd2,
    RESP    = 2'd3
  } arb_state_e;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

endpackage

// File: rtl/mem_align_check.sv
// Combinational legality check for a data-port access.
//   func3   : access size/sign code
//   addr_lo : low two byte-address bits
//   we      : 1 = store, 0 = load
//   illegal : 1 when the access must be refused (bad size code,
//             unsigned store, or misaligned half/word)
module mem_align_check
  import mem_arb_pkg::*;
(
  input  logic [2:0] func3,
  input  logic [1:0] addr_lo,
  input  logic       we,
  output logic       illegal
);

  always_comb begin
    illegal = 1'b1;
    case (func3)
      F3_B:    illegal = 1'b0;
      F3_H:    illegal = addr_lo[0];
      F3_W:    illegal = |addr_lo;
      F3_BU:   illegal = we;
      F3_HU:   illegal = we | addr_lo[0];
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one sync-write/async-read memory port between a
// fetch requester (word reads) and a data requester (loads/stores).
//   clk, rst                 : clock, synchronous active-high reset
//   i_req/i_addr             : fetch request (held until i_ack)
//   i_ack/i_rdata            : fetch response
//   d_req/d_we/d_addr/d_wdata/d_func3 : data request (held until d_ack)
//   d_ack/d_rdata/d_err      : data response, d_err flags illegal access
//   mem_*                    : memory side, one access per SERVE cycle
// Each transaction is grant edge -> SERVE (1 cycle) -> RESP (ack cycle).
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 12,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [31:0]       i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [2:0]        d_func3,
  output logic              d_ack,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [2:0]        mem_func3,
  input  logic [31:0]       mem_rdata
);

  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

  arb_state_e        state, state_n;
  logic              grant_d, grant_i;
  logic [SW-1:0]     starve;
  logic [ADDR_W-1:0] lat_addr;
  logic [31:0]       lat_wdata;
  logic [2:0]        lat_func3;
  logic              lat_we;
  logic              resp_d;   // RESP belongs to the data port
  logic              err_q;
  logic              illegal;

  mem_align_check u_chk (
    .func3   (lat_func3),
    .addr_lo (lat_addr[1:0]),
    .we      (lat_we),
    .illegal (illegal)
  );

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // next state; RESP only looks at the port that was not just acked
  always_comb begin
    state_n = state;
    grant_d = 1'b0;
    grant_i = 1'b0;
    case (state)
      IDLE: begin
        if (d_req && !(i_req && starve == STARVE_LIM)) grant_d = 1'b1;
        else if (i_req)                                 grant_i = 1'b1;
      end
      RESP: begin
        if (resp_d) grant_i = i_req;
        else        grant_d = d_req;
      end
      default: ;
    endcase
    if (state == SERVE_D || state == SERVE_I) state_n = RESP;
    else if (grant_d)                          state_n = SERVE_D;
    else if (grant_i)                          state_n = SERVE_I;
    else                                       state_n = IDLE;
  end

  // request latches, starve counter, response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      starve    <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_func3 <= '0;
      lat_we    <= 1'b0;
      resp_d    <= 1'b0;
      err_q     <= 1'b0;
      i_rdata   <= '0;
      d_rdata   <= '0;
    end else begin
      if (grant_d) begin
        lat_addr  <= d_addr;
        lat_wdata <= d_wdata;
        lat_func3 <= d_func3;
        lat_we    <= d_we;
        if (i_req && starve != STARVE_LIM) starve <= starve + 1'b1;
      end
      if (grant_i) begin
        lat_addr  <= i_addr;
        lat_wdata <= '0;
        lat_func3 <= F3_W;
        lat_we    <= 1'b0;
        starve    <= '0;
      end
      if (state == SERVE_D) begin
        resp_d  <= 1'b1;
        err_q   <= illegal;
        // refused accesses and stores return zero
        d_rdata <= (illegal || lat_we) ? 32'd0 : mem_rdata;
      end
      if (state == SERVE_I) begin
        resp_d  <= 1'b0;
        i_rdata <= mem_rdata;
      end
    end
  end

  // outputs; strobes gated by rst so a write in flight is aborted
  always_comb begin
    mem_addr  = lat_addr;
    mem_wdata = lat_wdata;
    mem_func3 = lat_func3;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    if (state == SERVE_I) begin
      mem_addr  = {lat_addr[ADDR_W-1:2], 2'b00};
      mem_func3 = F3_W;
      mem_read  = !rst;
    end
    if (state == SERVE_D && !illegal) begin
      mem_read  = !rst && !lat_we;
      mem_write = !rst && lat_we;
    end
    i_ack = (state == RESP) && !resp_d;
    d_ack = (state == RESP) && resp_d;
    d_err = d_ack && err_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

  localparam int STARVE_MAX = 4;

  logic        clk = 1'b0;
  logic        rst, preload;
  logic        i_req, i_ack, d_req, d_we, d_ack, d_err, mem_read, mem_write;
  logic [11:0] i_addr, d_addr, mem_addr;
  logic [31:0] i_rdata, d_wdata, d_rdata, mem_wdata, mem_rdata;
  logic [2:0]  d_func3, mem_func3;

  int total = 0;
  int bad   = 0;

  logic [31:0] mem    [0:1023];
  logic [31:0] shadow [0:1023];

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(12), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_func3(d_func3), .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_func3(mem_func3), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] init_word(input int w);
    return (w == 4) ? 32'hDEADBEEF : (32'hA500_0000 | 32'(w));
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [2:0] f,
                                        input logic [1:0] a, input logic [31:0] wd);
    logic [31:0] r;
    r = old;
    case (f[1:0])
      2'd0:    r[8*a +: 8] = wd[7:0];
      2'd1:    r[16*a[1] +: 16] = wd[15:0];
      default: r = wd;
    endcase
    return r;
  endfunction

  // reference legality rule, stated as set membership
  function automatic logic tb_ill(input logic [2:0] f, input logic [1:0] a, input logic we);
    return (f inside {3'd3, 3'd6, 3'd7}) || (we && (f inside {3'd4, 3'd5})) ||
           ((f inside {3'd1, 3'd5}) && a[0]) || (f == 3'd2 && a != 2'd0);
  endfunction

  // memory: sync write, async read
  always @(posedge clk) begin
    if (preload)
      for (int w = 0; w < 1024; w++) mem[w] <= init_word(w);
    else if (mem_write)
      mem[mem_addr[11:2]] <= merge(mem[mem_addr[11:2]], mem_func3, mem_addr[1:0], mem_wdata);
  end
  assign mem_rdata = mem[mem_addr[11:2]];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // one isolated data transaction, called and returning on a negedge
  task automatic d_txn(input logic we, input logic [2:0] f3, input logic [11:0] a,
                       input logic [31:0] wd, output logic ok, output logic err,
                       output logic [31:0] rd, output logic mr, output logic mw);
    d_req = 1'b1; d_we = we; d_func3 = f3; d_addr = a; d_wdata = wd;
    @(negedge clk); mr = mem_read; mw = mem_write;
    @(negedge clk); ok = d_ack; err = d_err; rd = d_rdata;
    d_req = 1'b0;
    @(negedge clk);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        exp_err;
    logic        chk_rd;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[17];

  initial begin
    logic        ok, err, mr, mw, e, legal;
    logic [31:0] rd;
    int          ack_kind[$];
    int          ack_cyc[$];
    logic        d_pend, i_pend;
    int          d_wait, i_wait, streak, mism;

    vecs[0]  = '{1'b0, 3'd2, 12'h010, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
    vecs[1]  = '{1'b1, 3'd2, 12'h013, 32'h11111111, 1'b1, 1'b1, 32'h0};
    vecs[2]  = '{1'b0, 3'd3, 12'h000, 32'h0,        1'b1, 1'b1, 32'h0};
    vecs[3]  = '{1'b0, 3'd6, 12'h004, 32'h0,        1'b1, 1'b1, 32'h0};
    vecs[4]  = '{1'b0, 3'd7, 12'h008, 32'h0,        1'b1, 1'b1, 32'h0};
    vecs[5]  = '{1'b1, 3'd4, 12'h010, 32'h22222222, 1'b1, 1'b1, 32'h0};
    vecs[6]  = '{1'b1, 3'd5, 12'h010, 32'h33333333, 1'b1, 1'b1, 32'h0};
    vecs[7]  = '{1'b0, 3'd1, 12'h011, 32'h0,        1'b1, 1'b1, 32'h0};
    vecs[8]  = '{1'b0, 3'd5, 12'h013, 32'h0,        1'b1, 1'b1, 32'h0};
    vecs[9]  = '{1'b0, 3'd1, 12'h012, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
    vecs[10] = '{1'b0, 3'd0, 12'h013, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
    vecs[11] = '{1'b0, 3'd4, 12'h011, 32'h0,        1'b0, 1'b1, 32'hDEADBEEF};
    vecs[12] = '{1'b0, 3'd2, 12'h012, 32'h0,        1'b1, 1'b1, 32'h0};
    vecs[13] = '{1'b1, 3'd1, 12'h01A, 32'h0000CAFE, 1'b0, 1'b0, 32'h0};
    vecs[14] = '{1'b0, 3'd2, 12'h018, 32'h0,        1'b0, 1'b1, 32'hCAFE0006};
    vecs[15] = '{1'b1, 3'd0, 12'h01D, 32'h00000077, 1'b0, 1'b0, 32'h0};
    vecs[16] = '{1'b0, 3'd2, 12'h01C, 32'h0,        1'b0, 1'b1, 32'hA5007707};

    for (int w = 0; w < 1024; w++) shadow[w] = init_word(w);
    rst = 1'b1; preload = 1'b1;
    i_req = 1'b0; i_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0;
    d_wdata = '0; d_func3 = '0;
    repeat (3) @(negedge clk);

    // reset state
    chk("rst_i_ack", i_ack, 0);
    chk("rst_d_ack", d_ack, 0);
    chk("rst_d_err", d_err, 0);
    chk("rst_i_rdata", i_rdata, 0);
    chk("rst_d_rdata", d_rdata, 0);
    chk("rst_mem_read", mem_read, 0);
    chk("rst_mem_write", mem_write, 0);
    preload = 1'b0; rst = 1'b0;
    @(negedge clk);

    // table of isolated data accesses: legality, strobes, latency, data
    for (int k = 0; k < 17; k++) begin
      d_txn(vecs[k].we, vecs[k].f3, vecs[k].addr, vecs[k].wdata, ok, err, rd, mr, mw);
      chk($sformatf("vec%0d_ack", k), ok, 1);
      chk($sformatf("vec%0d_err", k), err, vecs[k].exp_err);
      chk($sformatf("vec%0d_mem_read", k), mr, !vecs[k].exp_err && !vecs[k].we);
      chk($sformatf("vec%0d_mem_write", k), mw, !vecs[k].exp_err && vecs[k].we);
      if (vecs[k].chk_rd) chk($sformatf("vec%0d_rdata", k), rd, vecs[k].exp_rd);
    end
    shadow[6] = 32'hCAFE0006;
    shadow[7] = 32'hA5007707;
    chk("illegal_write_mem_010", mem[4], 32'hDEADBEEF);

    // misaligned fetch is served as the enclosing word
    i_req = 1'b1; i_addr = 12'h006;
    @(negedge clk);
    chk("fetch_mem_read", mem_read, 1);
    chk("fetch_mem_addr", mem_addr, 12'h004);
    chk("fetch_mem_func3", mem_func3, 3'd2);
    @(negedge clk);
    chk("fetch_i_ack", i_ack, 1);
    chk("fetch_d_ack", d_ack, 0);
    chk("fetch_i_rdata", i_rdata, shadow[1]);
    i_req = 1'b0;
    @(negedge clk);

    // both ports held: D first, then strict alternation, two cycles per grant
    d_req = 1'b1; d_we = 1'b0; d_func3 = 3'd2; d_addr = 12'h010;
    i_req = 1'b1; i_addr = 12'h00C;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (d_ack) begin ack_kind.push_back(0); ack_cyc.push_back(c); end
      if (i_ack) begin ack_kind.push_back(1); ack_cyc.push_back(c); end
    end
    chk("alt_i_rdata", i_rdata, shadow[3]);
    chk("alt_d_rdata", d_rdata, 32'hDEADBEEF);
    d_req = 1'b0; i_req = 1'b0;
    repeat (2) @(negedge clk);
    chk("alt_ack_count", ack_kind.size(), 6);
    for (int k = 0; k < ack_kind.size() && k < 6; k++) begin
      chk($sformatf("alt%0d_port", k), ack_kind[k], k % 2);
      chk($sformatf("alt%0d_cycle", k), ack_cyc[k], 2 * (k + 1));
    end

    // reset while a write is in its SERVE cycle
    d_req = 1'b1; d_we = 1'b1; d_func3 = 3'd2; d_addr = 12'h020; d_wdata = 32'h12345678;
    @(negedge clk);
    chk("rstw_pre_mem_write", mem_write, 1);
    rst = 1'b1;
    #1;
    chk("rstw_mem_write_gated", mem_write, 0);
    @(negedge clk);
    chk("rstw_d_ack", d_ack, 0);
    chk("rstw_i_ack", i_ack, 0);
    chk("rstw_d_err", d_err, 0);
    chk("rstw_d_rdata", d_rdata, 0);
    chk("rstw_i_rdata", i_rdata, 0);
    chk("rstw_mem_read", mem_read, 0);
    rst = 1'b0; d_req = 1'b0;
    @(negedge clk);
    chk("rstw_no_ack_after", d_ack, 0);
    chk("rstw_mem_020", mem[8], shadow[8]);

    // randomized traffic against shadow memory and legality rule
    d_pend = 1'b0; i_pend = 1'b0; d_wait = 0; i_wait = 0; streak = 0;
    for (int cyc = 0; cyc < 3030; cyc++) begin
      @(negedge clk);
      if (mem_write) begin
        legal = d_pend && d_we && !tb_ill(d_func3, d_addr[1:0], d_we) && mem_addr == d_addr;
        chk("rnd_mem_write_owner", legal, 1);
      end
      if (mem_read) begin
        legal = (d_pend && !d_we && !tb_ill(d_func3, d_addr[1:0], d_we) && mem_addr == d_addr) ||
                (i_pend && mem_addr == {i_addr[11:2], 2'b00});
        chk("rnd_mem_read_owner", legal, 1);
      end
      if (d_ack || i_ack) chk("rnd_single_ack", d_ack && i_ack, 0);
      if (d_ack) begin
        chk("rnd_d_ack_owner", d_pend, 1);
        if (d_pend) begin
          e = tb_ill(d_func3, d_addr[1:0], d_we);
          chk("rnd_d_err", d_err, e);
          if (e) chk("rnd_d_rdata_err", d_rdata, 0);
          else if (!d_we) chk("rnd_d_rdata", d_rdata, shadow[d_addr[11:2]]);
          else shadow[d_addr[11:2]] = merge(shadow[d_addr[11:2]], d_func3, d_addr[1:0], d_wdata);
          if (i_pend) begin
            streak++;
            chk("rnd_starve_bound", streak <= STARVE_MAX, 1);
          end
        end
        d_pend = 1'b0; d_req = 1'b0;
      end
      if (i_ack) begin
        chk("rnd_i_ack_owner", i_pend, 1);
        if (i_pend) chk("rnd_i_rdata", i_rdata, shadow[i_addr[11:2]]);
        i_pend = 1'b0; i_req = 1'b0; streak = 0;
      end
      if (d_pend && ++d_wait > 8) begin
        total++; bad++;
        $display("FAIL rnd_d_timeout: no ack after %0d cycles, want <= 8", d_wait);
        d_pend = 1'b0; d_req = 1'b0;
      end
      if (i_pend && ++i_wait > 8) begin
        total++; bad++;
        $display("FAIL rnd_i_timeout: no ack after %0d cycles, want <= 8", i_wait);
        i_pend = 1'b0; i_req = 1'b0;
      end
      if (cyc < 3000 && !d_pend && $urandom_range(1, 0) == 1) begin
        d_pend = 1'b1; d_wait = 0; d_req = 1'b1;
        d_we = 1'($urandom_range(1, 0));
        d_func3 = 3'($urandom_range(7, 0));
        d_addr = 12'($urandom_range(127, 0));
        d_wdata = $urandom;
      end
      if (cyc < 3000 && !i_pend && $urandom_range(4, 0) < 2) begin
        i_pend = 1'b1; i_wait = 0; i_req = 1'b1;
        i_addr = 12'($urandom_range(127, 0));
      end
    end
    chk("rnd_drained", d_pend || i_pend, 0);

    mism = 0;
    for (int w = 0; w < 1024; w++) if (mem[w] !== shadow[w]) mism++;
    chk("final_mem_words_differing", mism, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
